// File: rtl/operand_pc_select.sv
// -----------------------------------------------------------------------------
// operand_pc_select
//
// Datapath steering for the single-cycle RV64 core. It picks ALU operand A
// (rs1 or pc) and ALU operand B (rs2 or immediate), and it picks the next PC
// (pc+4, jump target, JALR target or conditional branch target).
//
// The operand and next-PC paths are purely combinational. Reset does not gate
// them. Only redirect_q and, when enabled, misalign_err are clocked.
//
// Optional feature macro: OPSEL_MISALIGN_CHECK_EN
//   defined   : misalign_err is a sticky flag. It is set when a redirect
//               target has next_pc[1:0] != 0 and is cleared only by reset.
//   undefined : misalign_err is tied to 0 and no flop is built.
//
// Ports
//   clock        in   1     system clock
//   reset        in   1     synchronous, active-high reset
//   pc           in   XLEN  current PC
//   rs1, rs2     in   XLEN  register-file read data
//   immediate    in   XLEN  sign-extended immediate
//   A_select     in   1     0 = rs1, 1 = pc
//   B_select     in   1     0 = rs2, 1 = immediate
//   pc_plus4     in   XLEN  sequential PC, computed externally
//   alu_result   in   XLEN  jump / branch target from the ALU
//   pc_select    in   2     00 seq, 01 jal, 10 jalr, 11 branch
//   br_taken     in   1     branch comparator result (used only for 11)
//   amuxOutput   out  XLEN  ALU operand A
//   bmuxOutput   out  XLEN  ALU operand B
//   next_pc      out  XLEN  next PC
//   redirect     out  1     next_pc source is not pc_plus4
//   redirect_q   out  1     redirect, registered
//   misalign_err out  1     sticky misaligned-target flag
// -----------------------------------------------------------------------------
module operand_pc_select #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] immediate,
  input  logic            A_select,
  input  logic            B_select,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] alu_result,
  input  logic [1:0]      pc_select,
  input  logic            br_taken,
  output logic [XLEN-1:0] amuxOutput,
  output logic [XLEN-1:0] bmuxOutput,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            redirect_q,
  output logic            misalign_err
);

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JAL    = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  logic [XLEN-1:0] w_next_pc;
  logic            w_redirect;
  logic            r_redirect_q;

  // Operand muxes. The ternary lets an unknown select propagate as X.
  assign amuxOutput = A_select ? pc        : rs1;
  assign bmuxOutput = B_select ? immediate : rs2;

  // Next-PC mux and redirect decode.
  // NOTE: every always_comb output gets a default before the case. This rules
  // out an inferred latch on any path the case does not cover.
  always_comb begin
    w_next_pc  = 'x;
    w_redirect = 1'bx;
    case (pc_select)
      PC_SEQ: begin
        w_next_pc  = pc_plus4;
        w_redirect = 1'b0;
      end
      PC_JAL: begin
        w_next_pc  = alu_result;
        w_redirect = 1'b1;
      end
      PC_JALR: begin
        w_next_pc  = {alu_result[XLEN-1:1], 1'b0};
        w_redirect = 1'b1;
      end
      PC_BRANCH: begin
        // redirect follows the chosen path, not a value compare. A taken
        // branch whose target equals pc_plus4 still counts as a redirect.
        w_next_pc  = br_taken ? alu_result : pc_plus4;
        w_redirect = br_taken;
      end
      default: begin
        // Unknown select: leave the X defaults in place so they propagate.
        w_next_pc  = 'x;
        w_redirect = 1'bx;
      end
    endcase
  end

  assign next_pc  = w_next_pc;
  assign redirect = w_redirect;

  // Registered redirect for the flush / trace logic.
  // NOTE: sequential state uses non-blocking assignment. All flops then sample
  // the pre-edge values, with no ordering race between always_ff blocks.
  always_ff @(posedge clock) begin
    if (reset) r_redirect_q <= 1'b0;
    else       r_redirect_q <= w_redirect;
  end

  assign redirect_q = r_redirect_q;

`ifdef OPSEL_MISALIGN_CHECK_EN
  logic r_misalign_err;

  // Sticky flag. Reset wins over a set on the same edge.
  always_ff @(posedge clock) begin
    if (reset)
      r_misalign_err <= 1'b0;
    else if (w_redirect && (w_next_pc[1:0] != 2'b00))
      r_misalign_err <= 1'b1;
  end

  assign misalign_err = r_misalign_err;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_pc_select.sv
// -----------------------------------------------------------------------------
// tb_operand_pc_select
//
// Self-checking bench for operand_pc_select. It runs a directed sequence
// followed by a randomized sequence. Expected values come from a behavioural
// model of the selection rules. Registered expectations are advanced once per
// clock edge inside clock_edge().
// -----------------------------------------------------------------------------
module tb_operand_pc_select;

  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic [XLEN-1:0] pc, rs1, rs2, immediate, pc_plus4, alu_result;
  logic            A_select, B_select, br_taken;
  logic [1:0]      pc_select;
  logic [XLEN-1:0] amuxOutput, bmuxOutput, next_pc;
  logic            redirect, redirect_q, misalign_err;

  int   checks   = 0;
  int   failures = 0;
  logic exp_rq   = 1'b0;
  logic exp_me   = 1'b0;

  operand_pc_select #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .pc(pc), .rs1(rs1), .rs2(rs2),
    .immediate(immediate), .A_select(A_select), .B_select(B_select),
    .pc_plus4(pc_plus4), .alu_result(alu_result), .pc_select(pc_select),
    .br_taken(br_taken), .amuxOutput(amuxOutput), .bmuxOutput(bmuxOutput),
    .next_pc(next_pc), .redirect(redirect), .redirect_q(redirect_q),
    .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: decide whether control flow leaves the sequential path,
  // then which address it lands on.
  function automatic logic model_redirect(input logic [1:0] sel, input logic bt);
    return !(sel == 2'd0 || (sel == 2'd3 && !bt));
  endfunction

  function automatic logic [XLEN-1:0] model_next_pc(input logic [1:0] sel,
      input logic bt, input logic [XLEN-1:0] p4, input logic [XLEN-1:0] alu);
    if (!model_redirect(sel, bt)) return p4;
    if (sel == 2'd2)              return alu & ~64'd1;
    return alu;
  endfunction

  task automatic check_comb(input string tag);
    check({tag, ".amux"},     amuxOutput, A_select ? pc : rs1);
    check({tag, ".bmux"},     bmuxOutput, B_select ? immediate : rs2);
    check({tag, ".next_pc"},  next_pc,
          model_next_pc(pc_select, br_taken, pc_plus4, alu_result));
    check({tag, ".redirect"}, {63'd0, redirect},
          {63'd0, model_redirect(pc_select, br_taken)});
  endtask

  // Advance the registered model from the pre-edge inputs, take the edge,
  // then check both flops away from the edge.
  task automatic clock_edge(input string tag);
    logic            red;
    logic [XLEN-1:0] tgt;
    red = model_redirect(pc_select, br_taken);
    tgt = model_next_pc(pc_select, br_taken, pc_plus4, alu_result);
    @(posedge clock);
    #1;
    exp_rq = reset ? 1'b0 : red;
`ifdef OPSEL_MISALIGN_CHECK_EN
    if (reset)                         exp_me = 1'b0;
    else if (red && tgt[1:0] != 2'b00) exp_me = 1'b1;
`endif
    check({tag, ".redirect_q"},   {63'd0, redirect_q},   {63'd0, exp_rq});
    check({tag, ".misalign_err"}, {63'd0, misalign_err}, {63'd0, exp_me});
  endtask

  task automatic step(input string tag);
    #1;
    check_comb(tag);
    clock_edge(tag);
  endtask

  initial begin
    // Reset held for two cycles. Combinational outputs still follow inputs.
    reset = 1'b1;
    rs1 = 64'h10; pc = 64'h1000; rs2 = 64'h20; immediate = 64'hFFFF_FFFF_FFFF_FFFC;
    pc_plus4 = 64'h1004; alu_result = 64'h2001; pc_select = 2'b00; br_taken = 1'b0;
    A_select = 1'b0; B_select = 1'b0;
    step("rst0");
    step("rst1");

    // All four A/B select combinations, still under reset.
    A_select = 1'b1; B_select = 1'b0; step("ab10");
    A_select = 1'b0; B_select = 1'b1; step("ab01");
    A_select = 1'b1; B_select = 1'b1; step("ab11");
    check("ab11.amux_const", amuxOutput, 64'h1000);
    check("ab11.bmux_const", bmuxOutput, 64'hFFFF_FFFF_FFFF_FFFC);

    // Sequential path and jumps, with fixed expected values.
    pc_select = 2'b01; #1;
    check("jal.next_pc_const", next_pc, 64'h2001);
    pc_select = 2'b10; #1;
    check("jalr.next_pc_const", next_pc, 64'h2000);
    check("jalr.redirect_const", {63'd0, redirect}, 64'd1);
    pc_select = 2'b00; step("seq");

    // Conditional branch.
    alu_result = 64'h0FF0; pc_select = 2'b11; br_taken = 1'b1; step("br_t");
    br_taken = 1'b0; step("br_nt");
    pc_select = 2'b00; br_taken = 1'b1; #1;
    check("seq_bt1.next_pc", next_pc, 64'h1004);
    br_taken = 1'b0; step("seq_bt0");
    // A taken branch whose target equals pc_plus4 still redirects.
    alu_result = 64'h1004; pc_select = 2'b11; br_taken = 1'b1; step("br_eq");

    // Registered redirect sequence.
    reset = 1'b0; alu_result = 64'h2000; pc_select = 2'b01; br_taken = 1'b0;
    step("rq_jal");
    check("rq_jal.const", {63'd0, redirect_q}, 64'd1);
    pc_select = 2'b00; step("rq_seq");
    pc_select = 2'b01; reset = 1'b1; step("rq_rst");
    check("rq_rst.const", {63'd0, redirect_q}, 64'd0);

    // Sticky misaligned-target flag. Also run in the default build, where the
    // model keeps the flag at 0.
    reset = 1'b0; alu_result = 64'h2002; pc_select = 2'b01; step("me_set");
    pc_select = 2'b00; step("me_hold");
    reset = 1'b1; step("me_rst");
    reset = 1'b0; alu_result = 64'h2001; pc_select = 2'b10; step("me_jalr");
    pc_select = 2'b00; reset = 1'b1; step("me_clr");

    // Randomized phase. Sparse reset keeps the sticky flag toggling.
    for (int i = 0; i < 300; i++) begin
      reset      = ($urandom_range(15) == 0);
      pc         = {$urandom, $urandom};
      rs1        = {$urandom, $urandom};
      rs2        = {$urandom, $urandom};
      immediate  = {$urandom, $urandom};
      pc_plus4   = {$urandom, $urandom};
      alu_result = {$urandom, $urandom};
      A_select   = 1'($urandom);
      B_select   = 1'($urandom);
      br_taken   = 1'($urandom);
      pc_select  = 2'($urandom);
      // Mostly aligned targets, so a reset can be seen holding the flag low.
      if ($urandom_range(3) != 0) alu_result[1:0] = 2'b00;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
